dc_mem_resp: RTL
================

DC_MEM_RESP -- requirements
Module: dc_mem_resp

Interface
REQ-001 SHALL have parameter MWIDTH, default 12: the RAM line-index width, giving 2**MWIDTH lines of 128 bits (64 KB).
REQ-002 SHALL have parameter LATENCY, default 4: cycles from request pulse to response pulse, legal range 2..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port dcw_start_rq, input, 1: one-cycle write request pulse.
REQ-006 SHALL have port dcw_in_addr, input, 32: write byte address; bits [MWIDTH+3:4] select the line.
REQ-007 SHALL have port dcw_in_mask, input, 16: per-byte write suppress (1 = byte i not written).
REQ-008 SHALL have port dcw_in_data, input, 128: write line data, byte i = bits [8i+7:8i].
REQ-009 SHALL have port dcw_finish_wresp, output, 1: one-cycle write-complete pulse.
REQ-010 SHALL have port dcr_start_rq, input, 1: one-cycle read request pulse.
REQ-011 SHALL have port dcr_rin_addr, input, 32: read byte address; line index as in REQ-006.
REQ-012 SHALL have port rdat_m_data, output, 128: read line data.
REQ-013 SHALL have port rdat_m_valid, output, 1: one-cycle pulse qualifying rdat_m_data.
REQ-014 SHALL have port finish_mrd, output, 1: read-complete pulse, asserted in the same cycle as rdat_m_valid.
REQ-015 SHALL have port rq_overflow, output, 1: sticky error flag for a request lost to a full pending slot.

Function
REQ-016 SHALL implement FSM states IDLE, WLAT, WRSP, RLAT and RRSP.
REQ-017 In IDLE with a write source (live pulse or pending slot), the FSM SHALL go to WLAT, latching addr/mask/data and loading the latency counter with LATENCY-2.
REQ-018 The RAM write SHALL occur on the edge leaving IDLE, writing only bytes whose mask bit is 0.
REQ-019 WLAT SHALL decrement the counter and go to WRSP at 0.
REQ-020 WRSP SHALL assert dcw_finish_wresp for exactly one cycle, then return to IDLE.
REQ-021 For a live request, the response pulse SHALL occur exactly LATENCY cycles after the request cycle.
REQ-022 Reads SHALL behave identically via RLAT/RRSP; RAM read data SHALL be registered into rdat_m_data.
REQ-023 rdat_m_valid and finish_mrd SHALL be asserted one cycle, in RRSP.
REQ-024 rdat_m_data SHALL hold its last value outside RRSP.
REQ-025 Arbitration in IDLE SHALL follow this priority: pending write, live write, pending read, live read.
REQ-026 A write and a read pulsed in the same cycle SHALL be served write first, with the read held in the pending slot.
REQ-027 Each channel SHALL have one pending slot, which captures a request pulse arriving while the FSM is not in IDLE, or while it is in IDLE but losing arbitration.
REQ-028 A pulse arriving while its channel's slot is full SHALL be dropped and SHALL set rq_overflow, which is cleared only by reset.
REQ-029 A read of a line written earlier SHALL return the post-write data, including a read queued behind the write.
REQ-030 Address bits above MWIDTH+3 SHALL be ignored, so addresses alias modulo the memory size.
REQ-031 A pending request SHALL start from IDLE one cycle after the prior response, giving its response 2*LATENCY+1 cycles after the original pulse (live-at-RRSP case).
REQ-032 An illegal state SHALL recover to IDLE.

Reset
REQ-033 On rst_n low, the design SHALL set FSM=IDLE and counter=0, clear both pending slots, and drive dcw_finish_wresp=0, rdat_m_valid=0, finish_mrd=0, rdat_m_data=0 and rq_overflow=0.
REQ-034 Reset SHALL NOT clear RAM contents.
REQ-035 Reset mid-operation SHALL abort the transaction with no response pulse; a RAM write already committed remains.

Structure
REQ-036 FSM state encodings SHALL be 3-bit defines (DCMR_IDLE..DCMR_RRSP) in the shared defines file, alongside the tiny-bus mask polarity constant.
REQ-037 The RAM SHALL be a sub-module ram_1r1w_be128 (1 read, 1 write, 16 byte enables, registered read, parameter width MWIDTH).

Verification
REQ-038 Write addr=0x00000120, mask=0x0000, data=0x0123..CDEF at cycle 10 -> dcw_finish_wresp=1 at cycle 14 only.
REQ-039 Read addr=0x00000120 at cycle 20 -> rdat_m_valid=finish_mrd=1 at cycle 24, rdat_m_data=0x0123..CDEF.
REQ-040 Masked write mask=0xFFFE, data byte0=0xAA to the same line, then read -> only byte0=0xAA, all other bytes unchanged.
REQ-041 Write and read to 0x200 in the same cycle T -> wresp at T+4, rdat_m_valid at T+9 carrying the new data.
REQ-042 Three read pulses at T, T+1, T+2 -> first two answered at T+4 and T+9, rq_overflow=1 from T+3.
REQ-043 rst_n low at T+2 of a write -> no wresp; a read afterward returns the written data.

Source files
------------

// File: rtl/dc_mem_resp_pkg.sv
// Shared types for the data-cache memory responder.
// FSM encodings, mask polarity and a byte-enable helper.
package dc_mem_resp_pkg;

   typedef enum logic [2:0] {
      DCMR_IDLE = 3'd0,
      DCMR_WLAT = 3'd1,
      DCMR_WRSP = 3'd2,
      DCMR_RLAT = 3'd3,
      DCMR_RRSP = 3'd4
   } dcmr_state_e;

   // Tiny-bus mask bit value meaning "do not write this byte".
   localparam logic TB_MASK_SUPPRESS = 1'b1;

   localparam int CNT_W = 4;

   function automatic logic [15:0] mask_to_be(
      input logic [15:0] mask
   );
      logic [15:0] be;
      for (int i = 0; i < 16; i++) begin
         be[i] = (mask[i] != TB_MASK_SUPPRESS);
      end
      return be;
   endfunction

endpackage

// File: rtl/dc_mem_resp_ram.sv
// 1R1W 128-bit line RAM with byte enables, registered read.
// Ports: clk, we/waddr/wbe/wdata write side, re/raddr/rdata read side.
module ram_1r1w_be128 #(
   parameter int MWIDTH = 12
) (
   input  logic              clk,
   input  logic              we,
   input  logic [MWIDTH-1:0] waddr,
   input  logic [15:0]       wbe,
   input  logic [127:0]      wdata,
   input  logic              re,
   input  logic [MWIDTH-1:0] raddr,
   output logic [127:0]      rdata
);

   logic [127:0] mem_q [2**MWIDTH];

   // No reset: contents survive rst_n.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 16; i++) begin
            if (wbe[i]) begin
               mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem_q[raddr];
      end
   end

endmodule

// File: rtl/dc_mem_resp.sv
// Fixed-latency memory responder for the data cache.
// Ports: clk, rst_n; dcw_* write channel with dcw_finish_wresp;
// dcr_* read channel with rdat_m_data/valid and finish_mrd;
// rq_overflow is a sticky lost-request flag.
module dc_mem_resp
   import dc_mem_resp_pkg::*;
#(
   parameter int MWIDTH  = 12,
   parameter int LATENCY = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         dcw_start_rq,
   input  logic [31:0]  dcw_in_addr,
   input  logic [15:0]  dcw_in_mask,
   input  logic [127:0] dcw_in_data,
   output logic         dcw_finish_wresp,
   input  logic         dcr_start_rq,
   input  logic [31:0]  dcr_rin_addr,
   output logic [127:0] rdat_m_data,
   output logic         rdat_m_valid,
   output logic         finish_mrd,
   output logic         rq_overflow
);

   localparam logic [CNT_W-1:0] CNT_LOAD =
      CNT_W'(LATENCY - 2);

   dcmr_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic              wp_vld_q, wp_vld_d;
   logic [MWIDTH-1:0] wp_line_q, wp_line_d;
   logic [15:0]       wp_mask_q, wp_mask_d;
   logic [127:0]      wp_data_q, wp_data_d;

   logic              rp_vld_q, rp_vld_d;
   logic [MWIDTH-1:0] rp_line_q, rp_line_d;

   logic         ovf_q, ovf_d;
   logic [127:0] rdat_q, rdat_d;

   logic              ram_we;
   logic [MWIDTH-1:0] ram_waddr;
   logic [15:0]       ram_wbe;
   logic [127:0]      ram_wdata;
   logic              ram_re;
   logic [MWIDTH-1:0] ram_raddr;
   logic [127:0]      ram_rdata;

   logic w_live_taken;
   logic r_live_taken;

   logic [MWIDTH-1:0] w_live_line;
   logic [MWIDTH-1:0] r_live_line;

   assign w_live_line = dcw_in_addr[MWIDTH+3:4];
   assign r_live_line = dcr_rin_addr[MWIDTH+3:4];

   // Upper bits alias; low nibble is the byte offset.
   logic unused_addr;
   assign unused_addr = ^{dcw_in_addr[31:MWIDTH+4],
                          dcw_in_addr[3:0],
                          dcr_rin_addr[31:MWIDTH+4],
                          dcr_rin_addr[3:0]};

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      wp_vld_d     = wp_vld_q;
      wp_line_d    = wp_line_q;
      wp_mask_d    = wp_mask_q;
      wp_data_d    = wp_data_q;
      rp_vld_d     = rp_vld_q;
      rp_line_d    = rp_line_q;
      ovf_d        = ovf_q;
      rdat_d       = rdat_q;
      ram_we       = 1'b0;
      ram_waddr    = w_live_line;
      ram_wbe      = mask_to_be(dcw_in_mask);
      ram_wdata    = dcw_in_data;
      ram_re       = 1'b0;
      ram_raddr    = r_live_line;
      w_live_taken = 1'b0;
      r_live_taken = 1'b0;

      case (state_q)
         DCMR_IDLE: begin
            // RAM access is issued on the edge leaving IDLE.
            if (wp_vld_q) begin
               ram_we    = 1'b1;
               ram_waddr = wp_line_q;
               ram_wbe   = mask_to_be(wp_mask_q);
               ram_wdata = wp_data_q;
               wp_vld_d  = 1'b0;
               cnt_d     = CNT_LOAD;
               state_d   = DCMR_WLAT;
            end else if (dcw_start_rq) begin
               ram_we       = 1'b1;
               w_live_taken = 1'b1;
               cnt_d        = CNT_LOAD;
               state_d      = DCMR_WLAT;
            end else if (rp_vld_q) begin
               ram_re    = 1'b1;
               ram_raddr = rp_line_q;
               rp_vld_d  = 1'b0;
               cnt_d     = CNT_LOAD;
               state_d   = DCMR_RLAT;
            end else if (dcr_start_rq) begin
               ram_re       = 1'b1;
               r_live_taken = 1'b1;
               cnt_d        = CNT_LOAD;
               state_d      = DCMR_RLAT;
            end
         end
         DCMR_WLAT: begin
            if (cnt_q == '0) begin
               state_d = DCMR_WRSP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DCMR_WRSP: begin
            state_d = DCMR_IDLE;
         end
         DCMR_RLAT: begin
            if (cnt_q == '0) begin
               rdat_d  = ram_rdata;
               state_d = DCMR_RRSP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DCMR_RRSP: begin
            state_d = DCMR_IDLE;
         end
         default: begin
            state_d = DCMR_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Untaken pulses park in their slot; a slot freed
      // this cycle by the FSM can be refilled at once.
      if (dcw_start_rq && !w_live_taken) begin
         if (wp_vld_d) begin
            ovf_d = 1'b1;
         end else begin
            wp_vld_d  = 1'b1;
            wp_line_d = w_live_line;
            wp_mask_d = dcw_in_mask;
            wp_data_d = dcw_in_data;
         end
      end

      if (dcr_start_rq && !r_live_taken) begin
         if (rp_vld_d) begin
            ovf_d = 1'b1;
         end else begin
            rp_vld_d  = 1'b1;
            rp_line_d = r_live_line;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= DCMR_IDLE;
         cnt_q     <= '0;
         wp_vld_q  <= 1'b0;
         wp_line_q <= '0;
         wp_mask_q <= '0;
         wp_data_q <= '0;
         rp_vld_q  <= 1'b0;
         rp_line_q <= '0;
         ovf_q     <= 1'b0;
         rdat_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wp_vld_q  <= wp_vld_d;
         wp_line_q <= wp_line_d;
         wp_mask_q <= wp_mask_d;
         wp_data_q <= wp_data_d;
         rp_vld_q  <= rp_vld_d;
         rp_line_q <= rp_line_d;
         ovf_q     <= ovf_d;
         rdat_q    <= rdat_d;
      end
   end

   ram_1r1w_be128 #(
      .MWIDTH (MWIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wbe   (ram_wbe),
      .wdata (ram_wdata),
      .re    (ram_re),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   assign dcw_finish_wresp = (state_q == DCMR_WRSP);
   assign rdat_m_valid     = (state_q == DCMR_RRSP);
   assign finish_mrd       = (state_q == DCMR_RRSP);
   assign rdat_m_data      = rdat_q;
   assign rq_overflow      = ovf_q;

endmodule
